fir_bram_arbiter: RTL and testbench

- Shares one single-port 11-word coefficient/data BRAM (bram11 interface: CLK, WE[3:0], EN, Di, Do, A[11:0] byte address) between two requesters: the configuration path (coefficient load/readback) and the FIR engine (tap fetch).
- Round-robin arbitration with bounded bursts.
- Routes each read return to the requester that issued it.
- Sits between the FIR top-level control logic and the BRAM instance.

---
 rtl/fir_bram_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_fir_bram_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_bram_arbiter.sv
// fir_bram_arbiter: shares one single-port coefficient/data BRAM between the
// configuration path and the FIR engine. Round-robin with bounded bursts,
// one beat per cycle (including across owner switches), and one-cycle read
// returns routed back to the requester that issued them.
// Optional: define FIR_BRAM_ARB_ADDR_CHECK_EN to suppress BRAM access for
// misaligned/out-of-range beats, return 32'hDEADBEEF for them, and raise a
// sticky err_o.
module fir_bram_arbiter #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 11,
    parameter int MAX_BURST  = 4
) (
    input  logic                  CLK,
    input  logic                  RSTn,
    input  logic                  cfg_req,
    input  logic [3:0]            cfg_we,
    input  logic [ADDR_WIDTH-1:0] cfg_addr,
    input  logic [DATA_WIDTH-1:0] cfg_wdata,
    output logic                  cfg_gnt,
    output logic                  cfg_rvalid,
    output logic [DATA_WIDTH-1:0] cfg_rdata,
    input  logic                  eng_req,
    input  logic [3:0]            eng_we,
    input  logic [ADDR_WIDTH-1:0] eng_addr,
    input  logic [DATA_WIDTH-1:0] eng_wdata,
    output logic                  eng_gnt,
    output logic                  eng_rvalid,
    output logic [DATA_WIDTH-1:0] eng_rdata,
    input  logic                  eng_lock,
    output logic                  bram_en,
    output logic [3:0]            bram_we,
    output logic [ADDR_WIDTH-1:0] bram_a,
    output logic [DATA_WIDTH-1:0] bram_di,
    input  logic [DATA_WIDTH-1:0] bram_do
`ifdef FIR_BRAM_ARB_ADDR_CHECK_EN
    ,
    output logic                  err_o
`endif
);

    typedef enum logic [1:0] {IDLE, OWN_CFG, OWN_ENG} state_t;

    localparam logic [3:0] MAXB = 4'(MAX_BURST);

    state_t          state, state_nxt;
    logic            last_eng, last_nxt;   // last_owner: 0 = CFG, 1 = ENG
    logic [3:0]      burst_cnt, burst_nxt;
    logic            gnt_c, gnt_e;
    logic            cfg_el, eng_el;

    logic                  beat;
    logic                  bad;
    logic [3:0]            b_we;
    logic [ADDR_WIDTH-1:0] b_addr;
    logic [DATA_WIDTH-1:0] b_wdata;

    logic                  rd_pend, rd_eng;
    logic [DATA_WIDTH-1:0] ret_data;
    logic [DATA_WIDTH-1:0] cfg_rdata_q, eng_rdata_q;

    // eng_lock masks config eligibility so a running engine owns the BRAM
    assign cfg_el = cfg_req & ~eng_lock;
    assign eng_el = eng_req;

    // Next-state and grant: hand-over grants the other side in the same cycle
    always_comb begin
        state_nxt = state;
        last_nxt  = last_eng;
        burst_nxt = burst_cnt;
        gnt_c     = 1'b0;
        gnt_e     = 1'b0;
        unique case (state)
            IDLE: begin
                if (cfg_el && (!eng_el || last_eng)) begin
                    gnt_c     = 1'b1;
                    state_nxt = OWN_CFG;
                    burst_nxt = 4'd1;
                end else if (eng_el) begin
                    gnt_e     = 1'b1;
                    state_nxt = OWN_ENG;
                    burst_nxt = 4'd1;
                end
            end
            OWN_CFG: begin
                if (cfg_el && (burst_cnt < MAXB || !eng_el)) begin
                    gnt_c = 1'b1;
                    if (burst_cnt < MAXB) burst_nxt = burst_cnt + 4'd1;
                end else if (eng_el) begin
                    gnt_e     = 1'b1;
                    state_nxt = OWN_ENG;
                    last_nxt  = 1'b0;
                    burst_nxt = 4'd1;
                end else begin
                    state_nxt = IDLE;
                    burst_nxt = 4'd0;
                end
            end
            OWN_ENG: begin
                if (eng_el && (burst_cnt < MAXB || !cfg_el)) begin
                    gnt_e = 1'b1;
                    if (burst_cnt < MAXB) burst_nxt = burst_cnt + 4'd1;
                end else if (cfg_el) begin
                    gnt_c     = 1'b1;
                    state_nxt = OWN_CFG;
                    last_nxt  = 1'b1;
                    burst_nxt = 4'd1;
                end else begin
                    state_nxt = IDLE;
                    burst_nxt = 4'd0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Mux the granted requester onto the beat; grants are forced low in reset
    always_comb begin
        beat    = RSTn & (gnt_c | gnt_e);
        b_we    = gnt_e ? eng_we    : cfg_we;
        b_addr  = gnt_e ? eng_addr  : cfg_addr;
        b_wdata = gnt_e ? eng_wdata : cfg_wdata;
    end

`ifdef FIR_BRAM_ARB_ADDR_CHECK_EN
    localparam logic [ADDR_WIDTH-3:0] DEPTH_W = (ADDR_WIDTH-2)'(DEPTH);
    assign bad = (b_addr[1:0] != 2'b00) || (b_addr[ADDR_WIDTH-1:2] >= DEPTH_W);
`else
    assign bad = 1'b0;
`endif

    assign cfg_gnt = RSTn & gnt_c;
    assign eng_gnt = RSTn & gnt_e;
    assign bram_en = beat & ~bad;
    assign bram_we = bram_en ? b_we    : 4'b0;
    assign bram_a  = bram_en ? b_addr  : '0;
    assign bram_di = bram_en ? b_wdata : '0;

    // Arbiter state and read-return tracking
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state     <= IDLE;
            last_eng  <= 1'b0;
            burst_cnt <= 4'd0;
            rd_pend   <= 1'b0;
            rd_eng    <= 1'b0;
        end else begin
            state     <= state_nxt;
            last_eng  <= last_nxt;
            burst_cnt <= burst_nxt;
            rd_pend   <= beat && (b_we == 4'b0);
            rd_eng    <= gnt_e;
        end
    end

`ifdef FIR_BRAM_ARB_ADDR_CHECK_EN
    logic rd_err;

    // Remember rejected reads so their return carries the poison word
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            rd_err <= 1'b0;
            err_o  <= 1'b0;
        end else begin
            rd_err <= bad;
            if (beat && bad) err_o <= 1'b1;
        end
    end

    assign ret_data = rd_err ? DATA_WIDTH'(32'hDEAD_BEEF) : bram_do;
`else
    assign ret_data = bram_do;
`endif

    assign cfg_rvalid = rd_pend & ~rd_eng;
    assign eng_rvalid = rd_pend &  rd_eng;
    assign cfg_rdata  = cfg_rvalid ? ret_data : cfg_rdata_q;
    assign eng_rdata  = eng_rvalid ? ret_data : eng_rdata_q;

    // Hold each requester's last returned word between its returns
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            cfg_rdata_q <= '0;
            eng_rdata_q <= '0;
        end else begin
            if (cfg_rvalid) cfg_rdata_q <= ret_data;
            if (eng_rvalid) eng_rdata_q <= ret_data;
        end
    end

endmodule

// File: tb/tb_fir_bram_arbiter.sv
// Bench for fir_bram_arbiter: behavioural BRAM, a transaction-level model of
// the arbitration rules checked every cycle, plus directed literal checks.
module tb_fir_bram_arbiter;
    localparam int AW = 12, DW = 32, DEPTH = 11, MB = 4;

    logic          CLK = 1'b0;
    logic          RSTn = 1'b0;
    logic          cfg_req, eng_req, eng_lock;
    logic [3:0]    cfg_we, eng_we;
    logic [AW-1:0] cfg_addr, eng_addr;
    logic [DW-1:0] cfg_wdata, eng_wdata;
    logic          cfg_gnt, cfg_rvalid, eng_gnt, eng_rvalid;
    logic [DW-1:0] cfg_rdata, eng_rdata;
    logic          bram_en;
    logic [3:0]    bram_we;
    logic [AW-1:0] bram_a;
    logic [DW-1:0] bram_di;
    logic [DW-1:0] bram_do = '0;
`ifdef FIR_BRAM_ARB_ADDR_CHECK_EN
    logic          err_o;
    localparam bit ACHK = 1'b1;
`else
    localparam bit ACHK = 1'b0;
`endif

    int checks = 0, failures = 0;

    fir_bram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .MAX_BURST(MB)) dut (
        .CLK(CLK), .RSTn(RSTn),
        .cfg_req(cfg_req), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .cfg_gnt(cfg_gnt), .cfg_rvalid(cfg_rvalid), .cfg_rdata(cfg_rdata),
        .eng_req(eng_req), .eng_we(eng_we), .eng_addr(eng_addr), .eng_wdata(eng_wdata),
        .eng_gnt(eng_gnt), .eng_rvalid(eng_rvalid), .eng_rdata(eng_rdata),
        .eng_lock(eng_lock),
        .bram_en(bram_en), .bram_we(bram_we), .bram_a(bram_a), .bram_di(bram_di),
        .bram_do(bram_do)
`ifdef FIR_BRAM_ARB_ADDR_CHECK_EN
        , .err_o(err_o)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural single-port BRAM with byte enables and one-cycle read latency
    logic [DW-1:0] mem [DEPTH];
    always @(posedge CLK) begin : bram_model
        int idx;
        if (bram_en) begin
            idx = int'(bram_a[AW-1:2]);
            if (idx < DEPTH) begin
                for (int b = 0; b < 4; b++)
                    if (bram_we[b]) mem[idx][8*b +: 8] <= bram_di[8*b +: 8];
                if (bram_we == 4'b0) bram_do <= mem[idx];
            end
        end
    end

    // Reference model: owner 0=none 1=cfg 2=eng; run = beats in current burst
    int            m_own = 0, m_last = 1, m_run = 0, m_pown = 0;
    bit            m_pend = 1'b0, m_err = 1'b0;
    logic [DW-1:0] m_pdata = '0, m_crd = '0, m_erd = '0;
    logic [DW-1:0] ref_mem [DEPTH];

    always @(negedge CLK) begin : cmp
        bit ce, ee, bad, own_ok, oth_ok;
        int win, idx;
        logic [3:0] we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        if (!RSTn) begin
            chk("rst_cfg_gnt", cfg_gnt, 0);
            chk("rst_eng_gnt", eng_gnt, 0);
            chk("rst_bram_en", bram_en, 0);
            chk("rst_bram_we", bram_we, 0);
            chk("rst_rvalid", {cfg_rvalid, eng_rvalid}, 0);
            m_own = 0; m_last = 1; m_run = 0; m_pend = 0; m_err = 0;
            m_crd = '0; m_erd = '0;
        end else begin
            // read returns issued last cycle
            if (m_pend && m_pown == 1) m_crd = m_pdata;
            if (m_pend && m_pown == 2) m_erd = m_pdata;
            chk("cfg_rvalid", cfg_rvalid, m_pend && m_pown == 1);
            chk("eng_rvalid", eng_rvalid, m_pend && m_pown == 2);
            chk("cfg_rdata", cfg_rdata, m_crd);
            chk("eng_rdata", eng_rdata, m_erd);
`ifdef FIR_BRAM_ARB_ADDR_CHECK_EN
            chk("err_o", err_o, m_err);
`endif
            // who wins this cycle
            ce = cfg_req && !eng_lock;
            ee = eng_req;
            win = 0;
            if (m_own == 0) begin
                if (ce && ee) win = 3 - m_last;
                else if (ce) win = 1;
                else if (ee) win = 2;
            end else begin
                own_ok = (m_own == 1) ? ce : ee;
                oth_ok = (m_own == 1) ? ee : ce;
                if (own_ok && (m_run < MB || !oth_ok)) win = m_own;
                else if (oth_ok) win = 3 - m_own;
            end
            chk("cfg_gnt", cfg_gnt, win == 1);
            chk("eng_gnt", eng_gnt, win == 2);
            we = (win == 2) ? eng_we : cfg_we;
            a  = (win == 2) ? eng_addr : cfg_addr;
            d  = (win == 2) ? eng_wdata : cfg_wdata;
            idx = int'(a) / 4;
            bad = ACHK && ((a % 4) != 0 || idx >= DEPTH);
            chk("bram_en", bram_en, win != 0 && !bad);
            if (win != 0 && !bad) begin
                chk("bram_we", bram_we, we);
                chk("bram_a", bram_a, a);
                chk("bram_di", bram_di, d);
            end else begin
                chk("bram_we_idle", bram_we, 0);
            end
            // consequences of the beat
            m_pend = (win != 0) && (we == 4'b0);
            m_pown = win;
            m_pdata = bad ? 32'hDEAD_BEEF : (idx < DEPTH ? ref_mem[idx] : '0);
            if (win != 0 && bad) m_err = 1'b1;
            if (win != 0 && !bad && we != 4'b0 && idx < DEPTH)
                for (int b = 0; b < 4; b++)
                    if (we[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
            if (win == 0) begin
                m_own = 0; m_run = 0;
            end else if (win == m_own) begin
                if (m_run < MB) m_run++;
            end else begin
                if (m_own != 0) m_last = m_own;
                m_own = win; m_run = 1;
            end
        end
    end

    task automatic idle_in();
        cfg_req = 0; eng_req = 0; eng_lock = 0;
        cfg_we = 0; eng_we = 0; cfg_addr = 0; eng_addr = 0;
        cfg_wdata = 0; eng_wdata = 0;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    logic [1:0] cont_exp [9] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01};

    initial begin
        for (int i = 0; i < DEPTH; i++) begin mem[i] = '0; ref_mem[i] = '0; end
        idle_in();
        #2;
        chk("reset_outs", {cfg_gnt, eng_gnt, bram_en, bram_we, cfg_rvalid, eng_rvalid}, 0);
        chk("reset_rdata", cfg_rdata | eng_rdata, 0);
        repeat (2) @(posedge CLK);
        #1 RSTn = 1'b1;

        // cfg fills words 0..10 with their index
        for (int i = 0; i < DEPTH; i++) begin
            cfg_req = 1; cfg_we = 4'hF; cfg_addr = AW'(i * 4); cfg_wdata = DW'(i);
            @(negedge CLK);
            chk("wr_gnt", cfg_gnt, 1);
            step();
        end
        idle_in(); step();

        // back-to-back readback: each word returns one cycle after its grant
        for (int i = 0; i <= DEPTH; i++) begin
            if (i < DEPTH) begin cfg_req = 1; cfg_we = 0; cfg_addr = AW'(i * 4); end
            else idle_in();
            @(negedge CLK);
            if (i > 0) begin
                chk("rd_rvalid", cfg_rvalid, 1);
                chk("rd_data", cfg_rdata, i - 1);
                chk("rd_no_eng", eng_rvalid, 0);
            end
            step();
        end

        // partial write of the low half, then engine reads the merged word
        cfg_req = 1; cfg_we = 4'h3; cfg_addr = 8; cfg_wdata = 32'h1122_3344; step();
        idle_in(); eng_req = 1; eng_we = 0; eng_addr = 8;
        @(negedge CLK);
        chk("handover_gnt", {cfg_gnt, eng_gnt}, 2'b01);
        step();
        idle_in();
        @(negedge CLK);
        chk("part_rvalid", eng_rvalid, 1);
        chk("part_rdata", eng_rdata, 32'h0000_3344);
        chk("part_no_cfg", cfg_rvalid, 0);
        step(); step();

        // contention from idle: ENG x4, CFG x4, ENG with no bubble
        cfg_req = 1; eng_req = 1; cfg_addr = 4; eng_addr = 12;
        for (int i = 0; i < 9; i++) begin
            @(negedge CLK);
            chk("cont_gnt", {cfg_gnt, eng_gnt}, cont_exp[i]);
            chk("cont_en", bram_en, 1);
            step();
        end
        idle_in(); step(); step();

        // engine lock blocks config until released
        eng_lock = 1; cfg_req = 1; cfg_addr = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("lock_gnt", cfg_gnt, 0);
            chk("lock_en", bram_en, 0);
            step();
        end
        eng_lock = 0;
        #1 chk("unlock_gnt", cfg_gnt, 1);
        step(); idle_in(); step(); step();

        // leave last_owner=ENG, then reset while a cfg read is in flight
        eng_req = 1; eng_addr = 16; step();
        idle_in(); cfg_req = 1; cfg_addr = 4;
        @(negedge CLK);
        chk("pre_rst_gnt", cfg_gnt, 1);
        #1 RSTn = 1'b0;
        #1;
        chk("mid_rst_outs", {cfg_gnt, eng_gnt, bram_en, bram_we, cfg_rvalid, eng_rvalid}, 0);
        chk("mid_rst_a", bram_a, 0);
        idle_in(); step();
        @(negedge CLK);
        chk("rst_drop_rvalid", {cfg_rvalid, eng_rvalid}, 0);
        #1 RSTn = 1'b1;
        step();
        cfg_req = 1; eng_req = 1; cfg_addr = 0; eng_addr = 0;
        @(negedge CLK);
        chk("post_rst_tie", {cfg_gnt, eng_gnt}, 2'b01);
        step(); idle_in(); step(); step();

`ifdef FIR_BRAM_ARB_ADDR_CHECK_EN
        // out-of-range read returns the poison word and flags the error
        cfg_req = 1; cfg_we = 0; cfg_addr = 12'h02C;
        @(negedge CLK);
        chk("oor_gnt", cfg_gnt, 1);
        chk("oor_en", bram_en, 0);
        step(); idle_in();
        @(negedge CLK);
        chk("oor_rvalid", cfg_rvalid, 1);
        chk("oor_rdata", cfg_rdata, 32'hDEAD_BEEF);
        chk("oor_err", err_o, 1);
        step(); step();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
